alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have ports: Clock  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: ReqValid in 1, ReqReady out 1, ReqOp in 1 (0=ADD64, 1=MUL32), ReqX in 64, ReqY in 64 (MUL32 uses bits [31:0]).
REQ-004 SHALL have: RspValid out 1, RspReady in 1, RspResult out 64, RspFlags out 4 {Z,C,N,O}.
REQ-005 SHALL have ALU-side: AluA out 32, AluB out 32, AluFunSel out 5, AluWF out 1, AluOut in 32 (combinational from ALU), AluFlags in 4 {Z,C,N,O} (registered in ALU on Clock when AluWF=1).

Function
REQ-006 SHALL implement states IDLE, ADD_LO, ADD_HI, FLAGS, MUL_STEP, DONE.
REQ-007 ReqReady SHALL be 1 only in IDLE; request accepted on edge with ReqValid&&ReqReady; operands latched at that edge.
REQ-008 IDLE and DONE SHALL drive AluWF=0, AluFunSel=5'b10000 (pass A, 32-bit), AluA=AluB=0.
REQ-009 ADD64: ADD_LO drives AluA=X[31:0], AluB=Y[31:0], AluFunSel=5'b10100 (ADD), AluWF=1; captures AluOut into result[31:0].
REQ-010 ADD_HI (next cycle) drives X[63:32], Y[63:32], AluFunSel=5'b10101 (ADD with carry flag), AluWF=1; captures result[63:32].
REQ-011 FLAGS (one cycle, AluWF=0) SHALL capture RspFlags={result==64'b0, AluFlags[2], AluFlags[1], AluFlags[0]}, then go to DONE.
REQ-012 ADD64 RspValid SHALL rise 4 cycles after the accept edge.
REQ-013 MUL32: product P=0, multiplicand M=X[31:0], multiplier Q=Y[31:0], 5-bit counter=0 on accept.
REQ-014 Each MUL_STEP cycle: if Q[0]=1 drive AluA=P, AluB=M, AluFunSel=5'b10100, else AluA=P, AluFunSel=5'b10000; AluWF=0; P<=AluOut; M<=M<<1; Q<=Q>>1 (local shifts).
REQ-015 MUL_STEP SHALL run exactly 32 cycles regardless of operand values (no early exit); counter wrap 31->0 exits to DONE.
REQ-016 MUL32 result SHALL be {32'b0, P} (low 32 bits of product, overflow discarded); RspFlags={P==0, 0, P[31], 0}.
REQ-017 MUL32 RspValid SHALL rise 33 cycles after the accept edge.
REQ-018 DONE SHALL hold RspValid=1, RspResult and RspFlags stable until an edge with RspReady=1, then go to IDLE (ReqReady=1 next cycle); no back-to-back accept in DONE.
REQ-019 ReqValid during non-IDLE states SHALL be ignored; ALU flags SHALL NOT be written (AluWF=0) outside ADD_LO/ADD_HI.

Reset
REQ-020 Reset SHALL force IDLE, RspValid=0, RspResult=0, RspFlags=0, counter=0, P/M/Q=0, from any state including mid-operation; in-flight op discarded, no response.
REQ-021 Reset SHALL take priority over handshake on the same edge.

Structure
REQ-022 Package alu_seq_pkg SHALL hold FunSel constants (ADD32, ADC32, PASSA32), ReqOp codes, and the state enum.
REQ-023 Single module, no sub-module; the ALU is instantiated alongside it (bench or top), not inside.

Verification
REQ-024 ADD64 X=0x00000000_FFFFFFFF, Y=1 -> RspResult=0x00000001_00000000, RspFlags=4'b0000, RspValid 4 cycles after accept.
REQ-025 ADD64 X=0xFFFFFFFF_FFFFFFFF, Y=1 -> RspResult=0, Z=1, C=1; X=0x7FFFFFFF_FFFFFFFF, Y=1 -> 0x80000000_00000000, N=1, O=1.
REQ-026 MUL32 X=0x0000FFFF, Y=0x00010001 -> RspResult=0x00000000_FFFFFFFF, RspFlags=4'b0010, RspValid 33 cycles after accept.
REQ-027 MUL32 X=0x12345678, Y=0 -> RspResult=0, Z=1, still 33 cycles; AluWF=0 throughout.
REQ-028 RspReady held 0 for 5 cycles in DONE with ReqValid=1 -> RspValid/RspResult stable, ReqReady=0, no new accept.
REQ-029 Reset asserted in 10th MUL_STEP cycle -> next cycle ReqReady=1, RspValid=0, RspResult=0, AluWF=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for alu_op_sequencer:
//   - ALU function-select codes driven on o_alu_fun_sel
//   - request opcode encoding for i_req_op
//   - sequencer state enumeration
// ----------------------------------------------------------------------------
package alu_seq_pkg;

    // ALU function-select codes (5-bit)
    localparam logic [4:0] FunPassA32 = 5'b10000;  // out = A
    localparam logic [4:0] FunAdd32   = 5'b10100;  // out = A + B
    localparam logic [4:0] FunAdc32   = 5'b10101;  // out = A + B + C flag

    // Request opcodes
    localparam logic OpAdd64 = 1'b0;
    localparam logic OpMul32 = 1'b1;

    // Width of the multiply step counter; 32 steps wrap it back to zero
    localparam int unsigned MulCntW = 5;

    typedef enum logic [2:0] {
        StIdle,
        StAddLo,
        StAddHi,
        StFlags,
        StMulStep,
        StDone
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
// Sequences a 32-bit external ALU to perform either a 64-bit add (two
// chained 32-bit adds through the ALU carry flag) or a 32x32 multiply
// (32 fixed shift-and-add steps, low 32 product bits kept).
//
// Ports
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_req_valid/o_req_ready   request handshake (ready only when idle)
//   i_req_op                  0 = ADD64, 1 = MUL32
//   i_req_x, i_req_y          operands (MUL32 uses bits [31:0])
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_result, o_rsp_flags 64-bit result, flags {Z,C,N,O}
//   o_alu_a, o_alu_b          ALU operands
//   o_alu_fun_sel, o_alu_wf   ALU function select, flag write enable
//   i_alu_out, i_alu_flags    ALU combinational result, registered flags
// ----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_op,
    input  logic [63:0] i_req_x,
    input  logic [63:0] i_req_y,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [63:0] o_rsp_result,
    output logic [3:0]  o_rsp_flags,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [4:0]  o_alu_fun_sel,
    output logic        o_alu_wf,
    input  logic [31:0] i_alu_out,
    input  logic [3:0]  i_alu_flags
);

    seq_state_e         r_state;
    seq_state_e         w_state_next;
    logic [63:0]        r_x;
    logic [63:0]        r_y;
    logic [31:0]        r_p;
    logic [31:0]        r_m;
    logic [31:0]        r_q;
    logic [MulCntW-1:0] r_cnt;
    logic [63:0]        r_result;
    logic [3:0]         r_flags;
    logic               w_mul_last;

    // The ALU zero flag only covers 32 bits; the 64-bit Z is computed here.
    logic w_unused_alu_z;
    assign w_unused_alu_z = i_alu_flags[3];

    assign w_mul_last   = (r_cnt == {MulCntW{1'b1}});
    assign o_rsp_result = r_result;
    assign o_rsp_flags  = r_flags;

    always_comb begin
        w_state_next  = r_state;
        o_req_ready   = 1'b0;
        o_rsp_valid   = 1'b0;
        o_alu_a       = 32'd0;
        o_alu_b       = 32'd0;
        o_alu_fun_sel = FunPassA32;
        o_alu_wf      = 1'b0;
        case (r_state)
            StIdle: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_state_next = (i_req_op == OpMul32) ? StMulStep : StAddLo;
                end
            end
            StAddLo: begin
                o_alu_a       = r_x[31:0];
                o_alu_b       = r_y[31:0];
                o_alu_fun_sel = FunAdd32;
                o_alu_wf      = 1'b1;
                w_state_next  = StAddHi;
            end
            StAddHi: begin
                o_alu_a       = r_x[63:32];
                o_alu_b       = r_y[63:32];
                o_alu_fun_sel = FunAdc32;
                o_alu_wf      = 1'b1;
                w_state_next  = StFlags;
            end
            StFlags: begin
                w_state_next = StDone;
            end
            StMulStep: begin
                // Pass P through unchanged when the multiplier bit is clear.
                o_alu_a = r_p;
                if (r_q[0]) begin
                    o_alu_b       = r_m;
                    o_alu_fun_sel = FunAdd32;
                end
                if (w_mul_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_x      <= 64'd0;
            r_y      <= 64'd0;
            r_p      <= 32'd0;
            r_m      <= 32'd0;
            r_q      <= 32'd0;
            r_cnt    <= '0;
            r_result <= 64'd0;
            r_flags  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_x   <= i_req_x;
                        r_y   <= i_req_y;
                        r_p   <= 32'd0;
                        r_m   <= i_req_x[31:0];
                        r_q   <= i_req_y[31:0];
                        r_cnt <= '0;
                    end
                end
                StAddLo: r_result[31:0]  <= i_alu_out;
                StAddHi: r_result[63:32] <= i_alu_out;
                StFlags: r_flags <= {(r_result == 64'd0), i_alu_flags[2:0]};
                StMulStep: begin
                    r_p   <= i_alu_out;
                    r_m   <= r_m << 1;
                    r_q   <= r_q >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_result <= {32'd0, i_alu_out};
                        r_flags  <= {(i_alu_out == 32'd0), 1'b0, i_alu_out[31], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed self-checking bench for alu_op_sequencer with a behavioural
// 32-bit ALU (combinational result, flags registered when wf=1).
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [63:0] req_x;
    logic [63:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_fun;
    logic        alu_wf;
    logic [31:0] alu_out;
    logic [3:0]  alu_flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_x      (req_x),
        .i_req_y      (req_y),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_flags  (rsp_flags),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_fun_sel(alu_fun),
        .o_alu_wf     (alu_wf),
        .i_alu_out    (alu_out),
        .i_alu_flags  (alu_flags)
    );

    // Behavioural ALU: pass A, ADD, ADD-with-carry; flags {Z,C,N,O}
    logic [32:0] alu_sum;
    logic [3:0]  alu_flags_nxt;
    always_comb begin
        alu_sum = {1'b0, alu_a};
        case (alu_fun)
            5'b10100: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            5'b10101: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_flags[2]};
            default: ;
        endcase
        alu_flags_nxt[3] = (alu_sum[31:0] == 32'd0);
        alu_flags_nxt[2] = alu_sum[32];
        alu_flags_nxt[1] = alu_sum[31];
        alu_flags_nxt[0] = (alu_fun != 5'b10000) && (alu_a[31] == alu_b[31]) &&
                           (alu_sum[31] != alu_a[31]);
    end
    assign alu_out = alu_sum[31:0];

    always @(posedge clk) begin
        if (reset) alu_flags <= 4'd0;
        else if (alu_wf) alu_flags <= alu_flags_nxt;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for ready, present one request, return just after the accept edge.
    task automatic issue_req(input logic op, input logic [63:0] x, input logic [63:0] y);
        int n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: req_ready=%0b required 1", req_ready);
        end
        req_op    = op;
        req_x     = x;
        req_y     = y;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    // Count cycles (cycle 1 = first cycle after accept) until rsp_valid.
    task automatic wait_rsp(input int start, output int cyc, output int wf_cnt);
        cyc    = start;
        wf_cnt = 0;
        while (!rsp_valid && cyc < 100) begin
            wf_cnt += int'(alu_wf);
            step();
            cyc++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %0b required 1", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid: got %0b required 0", rsp_valid);
        end
        checks++;
        if (rsp_result !== 64'd0 || rsp_flags !== 4'd0) begin
            failures++;
            $display("FAIL reset_rsp_data: got %h/%b required 0/0000", rsp_result, rsp_flags);
        end
        checks++;
        if ({alu_a, alu_b, alu_fun, alu_wf} !== {32'd0, 32'd0, 5'b10000, 1'b0}) begin
            failures++;
            $display("FAIL reset_alu_idle: got a=%h b=%h fun=%b wf=%b required 0 0 10000 0",
                     alu_a, alu_b, alu_fun, alu_wf);
        end
    endtask

    task automatic test_add64(input logic [63:0] x, input logic [63:0] y,
                              input logic [63:0] exp_res, input logic [3:0] exp_flags,
                              input string name);
        int cyc;
        int wfc;
        issue_req(1'b0, x, y);
        checks++;
        if ({alu_a, alu_b, alu_fun, alu_wf} !== {x[31:0], y[31:0], 5'b10100, 1'b1}) begin
            failures++;
            $display("FAIL %s_add_lo: got a=%h b=%h fun=%b wf=%b required %h %h 10100 1",
                     name, alu_a, alu_b, alu_fun, alu_wf, x[31:0], y[31:0]);
        end
        step();
        checks++;
        if ({alu_a, alu_b, alu_fun, alu_wf} !== {x[63:32], y[63:32], 5'b10101, 1'b1}) begin
            failures++;
            $display("FAIL %s_add_hi: got a=%h b=%h fun=%b wf=%b required %h %h 10101 1",
                     name, alu_a, alu_b, alu_fun, alu_wf, x[63:32], y[63:32]);
        end
        wait_rsp(2, cyc, wfc);
        checks++;
        if (cyc !== 4) begin
            failures++;
            $display("FAIL %s_latency: got cycle %0d required 4", name, cyc);
        end
        checks++;
        if (rsp_result !== exp_res) begin
            failures++;
            $display("FAIL %s_result: got %h required %h", name, rsp_result, exp_res);
        end
        checks++;
        if (rsp_flags !== exp_flags) begin
            failures++;
            $display("FAIL %s_flags: got %b required %b", name, rsp_flags, exp_flags);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_ready: got %0b required 0", name, req_ready);
        end
        release_rsp();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_back_idle: got ready=%0b valid=%0b required 1 0",
                     name, req_ready, rsp_valid);
        end
    endtask

    task automatic test_mul32(input logic [63:0] x, input logic [63:0] y,
                              input logic [63:0] exp_res, input logic [3:0] exp_flags,
                              input string name);
        int cyc;
        int wfc;
        issue_req(1'b1, x, y);
        wait_rsp(1, cyc, wfc);
        checks++;
        if (cyc !== 33) begin
            failures++;
            $display("FAIL %s_latency: got cycle %0d required 33", name, cyc);
        end
        checks++;
        if (wfc !== 0) begin
            failures++;
            $display("FAIL %s_wf: got %0d wf cycles required 0", name, wfc);
        end
        checks++;
        if (rsp_result !== exp_res) begin
            failures++;
            $display("FAIL %s_result: got %h required %h", name, rsp_result, exp_res);
        end
        checks++;
        if (rsp_flags !== exp_flags) begin
            failures++;
            $display("FAIL %s_flags: got %b required %b", name, rsp_flags, exp_flags);
        end
        release_rsp();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_back_idle: got ready=%0b valid=%0b required 1 0",
                     name, req_ready, rsp_valid);
        end
    endtask

    // Response held in DONE while a new request is pending.
    task automatic test_hold();
        int cyc;
        int wfc;
        issue_req(1'b0, 64'd5, 64'd7);
        wait_rsp(1, cyc, wfc);
        req_valid = 1'b1;
        req_op    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 64'd12 || rsp_flags !== 4'b0000 ||
                req_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: got valid=%0b res=%h flags=%b ready=%0b required 1 c 0000 0",
                         i, rsp_valid, rsp_result, rsp_flags, req_ready);
            end
            step();
        end
        req_valid = 1'b0;
        release_rsp();
        step();
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_no_accept: got ready=%0b valid=%0b required 1 0",
                     req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen = 0;
        issue_req(1'b1, 64'h0000FFFF, 64'h00010001);
        for (int i = 1; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_hs: got ready=%0b valid=%0b required 1 0",
                     req_ready, rsp_valid);
        end
        checks++;
        if (rsp_result !== 64'd0 || rsp_flags !== 4'd0 || alu_wf !== 1'b0) begin
            failures++;
            $display("FAIL midreset_data: got res=%h flags=%b wf=%b required 0 0000 0",
                     rsp_result, rsp_flags, alu_wf);
        end
        for (int i = 0; i < 40; i++) begin
            seen += int'(rsp_valid);
            step();
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midreset_no_rsp: got %0d valid cycles required 0", seen);
        end
    endtask

    // Reset and a valid request on the same edge: reset wins, nothing accepted.
    task automatic test_reset_priority();
        req_valid = 1'b1;
        req_op    = 1'b0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || alu_wf !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority: got ready=%0b wf=%0b required 1 0", req_ready, alu_wf);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_x     = 64'd0;
        req_y     = 64'd0;
        rsp_ready = 1'b0;
        test_reset();
        test_add64(64'h00000000_FFFFFFFF, 64'd1, 64'h00000001_00000000, 4'b0000, "add_carry");
        test_add64(64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'd0, 4'b1100, "add_wrap");
        test_add64(64'h7FFFFFFF_FFFFFFFF, 64'd1, 64'h80000000_00000000, 4'b0011, "add_ovf");
        test_mul32(64'h0000FFFF, 64'h00010001, 64'h00000000_FFFFFFFF, 4'b0010, "mul_basic");
        test_mul32(64'h12345678, 64'd0, 64'd0, 4'b1000, "mul_zero");
        test_mul32(64'h12345678, 64'd3, 64'h00000000_369D0368, 4'b0000, "mul_three");
        test_mul32(64'hFFFFFFFF_80000001, 64'h12345678_00000003, 64'h00000000_80000003, 4'b0010,
                   "mul_trunc");
        test_hold();
        test_reset_mid_mul();
        test_reset_priority();
        test_add64(64'd5, 64'd7, 64'd12, 4'b0000, "add_after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
